nco_voice_allocator: RTL and testbench

- Polyphony scheduler for a bank of NUM_VOICES NCO voices.
- Accepts note-on and note-off events over a valid/ready handshake and picks a target voice for each.
- Drives the per-voice loadF/loadA/key_on controls plus one shared F/A load bus into the NCO bank.
- Sits between the upstream note decoder (which supplies the frequency word and amplitude) and the NCO instances.

---
 rtl/nco_voice_allocator.sv | 178 +++++++++++++++++
 tb/tb_nco_voice_allocator.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_voice_allocator.sv
// Polyphony scheduler: maps note-on/off events onto a bank of NCO voices,
// driving one-hot F/A load strobes, a shared load bus and per-voice gates.
module nco_voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int VIDX_W     = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  note_valid,
    output logic                  note_ready,
    input  logic                  note_on,
    input  logic [6:0]            note_num,
    input  logic [23:0]           note_F,
    input  logic [15:0]           note_A,
    input  logic                  panic,
    output logic [23:0]           F_bus,
    output logic [15:0]           A_bus,
    output logic [NUM_VOICES-1:0] loadF,
    output logic [NUM_VOICES-1:0] loadA,
    output logic [NUM_VOICES-1:0] key_on,
    output logic                  steal_pulse
);

    typedef enum logic [1:0] {IDLE, LOOKUP, RELEASE, LOAD} state_t;

    state_t                  state_q, state_d;
    logic                    ready_q, ready_d;
    logic                    ev_on_q, ev_on_d;
    logic [6:0]              ev_num_q, ev_num_d;
    logic [23:0]             ev_f_q, ev_f_d;
    logic [15:0]             ev_a_q, ev_a_d;
    logic [VIDX_W-1:0]       vsel_q, vsel_d;
    logic [VIDX_W-1:0]       steal_ptr_q, steal_ptr_d;
    logic [NUM_VOICES-1:0]   key_on_q, key_on_d;
    logic [NUM_VOICES-1:0]   load_q, load_d;
    logic [23:0]             f_bus_q, f_bus_d;
    logic [15:0]             a_bus_q, a_bus_d;
    logic                    steal_q, steal_d;
    logic [6:0]              voice_note_q [NUM_VOICES];
    logic [6:0]              voice_note_d [NUM_VOICES];

    logic                    accept;
    logic                    match_found, free_found;
    logic [VIDX_W-1:0]       match_idx, free_idx;

    assign accept = note_valid && ready_q && !panic;

    // Lowest-index sounding match and lowest-index free voice
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        free_found  = 1'b0;
        free_idx    = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!match_found && key_on_q[i] && voice_note_q[i] == ev_num_q) begin
                match_found = 1'b1;
                match_idx   = VIDX_W'(i);
            end
            if (!free_found && !key_on_q[i]) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(i);
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = LOOKUP;
            LOOKUP: begin
                if (!ev_on_q)         state_d = IDLE;
                else if (match_found) state_d = RELEASE;
                else if (free_found)  state_d = LOAD;
                else                  state_d = RELEASE;
            end
            RELEASE: state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (panic) state_d = IDLE;
    end

    always_comb begin
        ev_on_d      = ev_on_q;
        ev_num_d     = ev_num_q;
        ev_f_d       = ev_f_q;
        ev_a_d       = ev_a_q;
        vsel_d       = vsel_q;
        steal_ptr_d  = steal_ptr_q;
        key_on_d     = key_on_q;
        steal_d      = 1'b0;
        voice_note_d = voice_note_q;
        if (accept) begin
            ev_on_d  = note_on;
            ev_num_d = note_num;
            ev_f_d   = note_F;
            ev_a_d   = note_A;
        end
        unique case (state_q)
            LOOKUP: begin
                if (!ev_on_q) begin
                    if (match_found) key_on_d[match_idx] = 1'b0;
                end else if (match_found) begin
                    vsel_d = match_idx;
                end else if (free_found) begin
                    vsel_d = free_idx;
                end else begin
                    vsel_d  = steal_ptr_q;
                    steal_d = 1'b1;
                    if (steal_ptr_q == VIDX_W'(NUM_VOICES - 1)) steal_ptr_d = '0;
                    else steal_ptr_d = steal_ptr_q + VIDX_W'(1);
                end
            end
            RELEASE: key_on_d[vsel_q] = 1'b0;
            LOAD: begin
                key_on_d[vsel_q]     = 1'b1;
                voice_note_d[vsel_q] = ev_num_q;
            end
            default: ;
        endcase
        if (panic) begin
            key_on_d    = '0;
            steal_d     = 1'b0;
            steal_ptr_d = steal_ptr_q;
        end
        // Strobes and bus are registered so they line up with the LOAD cycle
        load_d  = (state_d == LOAD) ? (NUM_VOICES'(1) << vsel_d) : '0;
        f_bus_d = (state_d == LOAD) ? ev_f_q : f_bus_q;
        a_bus_d = (state_d == LOAD) ? ev_a_q : a_bus_q;
        ready_d = (state_d == IDLE) && !panic;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ready_q     <= 1'b1;
            ev_on_q     <= 1'b0;
            ev_num_q    <= '0;
            ev_f_q      <= '0;
            ev_a_q      <= '0;
            vsel_q      <= '0;
            steal_ptr_q <= '0;
            key_on_q    <= '0;
            load_q      <= '0;
            f_bus_q     <= '0;
            a_bus_q     <= '0;
            steal_q     <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) voice_note_q[i] <= '0;
        end else begin
            ready_q      <= ready_d;
            ev_on_q      <= ev_on_d;
            ev_num_q     <= ev_num_d;
            ev_f_q       <= ev_f_d;
            ev_a_q       <= ev_a_d;
            vsel_q       <= vsel_d;
            steal_ptr_q  <= steal_ptr_d;
            key_on_q     <= key_on_d;
            load_q       <= load_d;
            f_bus_q      <= f_bus_d;
            a_bus_q      <= a_bus_d;
            steal_q      <= steal_d;
            voice_note_q <= voice_note_d;
        end
    end

    assign note_ready  = ready_q;
    assign F_bus       = f_bus_q;
    assign A_bus       = a_bus_q;
    assign loadF       = load_q;
    assign loadA       = load_q;
    assign key_on      = key_on_q;
    assign steal_pulse = steal_q;

endmodule

// File: tb/tb_nco_voice_allocator.sv
// Directed bench for nco_voice_allocator: free/steal/retrigger/off,
// panic and mid-operation reset, against hand-computed expectations.
module tb_nco_voice_allocator;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        note_valid = 1'b0;
    logic        note_ready;
    logic        note_on = 1'b0;
    logic [6:0]  note_num = '0;
    logic [23:0] note_F = '0;
    logic [15:0] note_A = '0;
    logic        panic = 1'b0;
    logic [23:0] F_bus;
    logic [15:0] A_bus;
    logic [3:0]  loadF, loadA, key_on;
    logic        steal_pulse;

    int tests = 0;
    int failed = 0;

    nco_voice_allocator #(.NUM_VOICES(4), .VIDX_W(2)) dut (
        .Clk(Clk), .Reset(Reset), .note_valid(note_valid),
        .note_ready(note_ready), .note_on(note_on), .note_num(note_num),
        .note_F(note_F), .note_A(note_A), .panic(panic),
        .F_bus(F_bus), .A_bus(A_bus), .loadF(loadF), .loadA(loadA),
        .key_on(key_on), .steal_pulse(steal_pulse)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        panic = 1'b0;
        note_valid = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Present one event for a single edge (acceptance edge E0)
    task automatic send(input logic on, input logic [6:0] num,
                        input logic [23:0] f, input logic [15:0] a);
        note_on = on;
        note_num = num;
        note_F = f;
        note_A = a;
        note_valid = 1'b1;
        tick();
        note_valid = 1'b0;
    endtask

    task automatic play(input logic [6:0] num, input int cyc);
        send(1'b1, num, {17'h0, num}, 16'h1000);
        repeat (cyc) tick();
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tests++;
        if (key_on !== 4'b0000 || loadF !== 4'b0000 || loadA !== 4'b0000) begin
            failed++;
            $display("FAIL reset_strobes key=%b lf=%b la=%b exp=0", key_on, loadF, loadA);
        end
        tests++;
        if (F_bus !== 24'h0 || A_bus !== 16'h0 || steal_pulse !== 1'b0) begin
            failed++;
            $display("FAIL reset_bus F=%h A=%h st=%b exp=0", F_bus, A_bus, steal_pulse);
        end
        Reset = 1'b0;
        tick();
        tests++;
        if (note_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_ready act=%b exp=1", note_ready);
        end
    endtask

    task automatic test_free_voice();
        do_reset();
        send(1'b1, 7'd60, 24'h0A0000, 16'h8000);
        tests++;
        if (note_ready !== 1'b0 || loadF !== 4'b0000 || key_on !== 4'b0000) begin
            failed++;
            $display("FAIL free_e0 rdy=%b lf=%b key=%b exp 0/0000/0000", note_ready, loadF, key_on);
        end
        tick();
        tests++;
        if (loadF !== 4'b0001 || loadA !== 4'b0001) begin
            failed++;
            $display("FAIL free_load lf=%b la=%b exp=0001", loadF, loadA);
        end
        tests++;
        if (F_bus !== 24'h0A0000 || A_bus !== 16'h8000) begin
            failed++;
            $display("FAIL free_bus F=%h A=%h exp 0a0000/8000", F_bus, A_bus);
        end
        tests++;
        if (note_ready !== 1'b0 || key_on !== 4'b0000) begin
            failed++;
            $display("FAIL free_e1 rdy=%b key=%b exp 0/0000", note_ready, key_on);
        end
        tick();
        tests++;
        if (key_on !== 4'b0001 || loadF !== 4'b0000 || note_ready !== 1'b1) begin
            failed++;
            $display("FAIL free_e2 key=%b lf=%b rdy=%b exp 0001/0000/1", key_on, loadF, note_ready);
        end
        tests++;
        if (F_bus !== 24'h0A0000) begin
            failed++;
            $display("FAIL free_bus_hold F=%h exp=0a0000", F_bus);
        end
    endtask

    task automatic test_steal();
        do_reset();
        play(7'd60, 2);
        play(7'd62, 2);
        play(7'd64, 2);
        play(7'd67, 2);
        tests++;
        if (key_on !== 4'b1111) begin
            failed++;
            $display("FAIL steal_fill key=%b exp=1111", key_on);
        end
        send(1'b1, 7'd69, 24'h000045, 16'h1000);
        tick();
        tests++;
        if (steal_pulse !== 1'b1 || key_on !== 4'b1111) begin
            failed++;
            $display("FAIL steal_rel st=%b key=%b exp 1/1111", steal_pulse, key_on);
        end
        tick();
        tests++;
        if (steal_pulse !== 1'b0 || key_on !== 4'b1110 || loadF !== 4'b0001) begin
            failed++;
            $display("FAIL steal_load st=%b key=%b lf=%b exp 0/1110/0001", steal_pulse, key_on, loadF);
        end
        tick();
        tests++;
        if (key_on !== 4'b1111 || note_ready !== 1'b1) begin
            failed++;
            $display("FAIL steal_done key=%b rdy=%b exp 1111/1", key_on, note_ready);
        end
        send(1'b1, 7'd71, 24'h000047, 16'h1000);
        tick();
        tick();
        tests++;
        if (loadF !== 4'b0010 || key_on !== 4'b1101) begin
            failed++;
            $display("FAIL steal2_load lf=%b key=%b exp 0010/1101", loadF, key_on);
        end
        tick();
        send(1'b0, 7'd69, 24'h0, 16'h0);
        tick();
        tests++;
        if (key_on !== 4'b1110) begin
            failed++;
            $display("FAIL steal_note69_v0 key=%b exp=1110", key_on);
        end
    endtask

    task automatic test_note_off();
        do_reset();
        play(7'd60, 2);
        play(7'd62, 2);
        play(7'd64, 2);
        send(1'b0, 7'd62, 24'h0, 16'h0);
        tests++;
        if (key_on !== 4'b0111 || note_ready !== 1'b0) begin
            failed++;
            $display("FAIL off_e0 key=%b rdy=%b exp 0111/0", key_on, note_ready);
        end
        tick();
        tests++;
        if (key_on !== 4'b0101 || loadF !== 4'b0000 || note_ready !== 1'b1) begin
            failed++;
            $display("FAIL off_e1 key=%b lf=%b rdy=%b exp 0101/0000/1", key_on, loadF, note_ready);
        end
        send(1'b1, 7'd65, 24'h000041, 16'h2000);
        tick();
        tests++;
        if (loadF !== 4'b0010) begin
            failed++;
            $display("FAIL off_reuse lf=%b exp=0010", loadF);
        end
        tick();
        tests++;
        if (key_on !== 4'b0111) begin
            failed++;
            $display("FAIL off_reuse_key key=%b exp=0111", key_on);
        end
    endtask

    task automatic test_off_unmatched();
        send(1'b0, 7'd50, 24'h0, 16'h0);
        tick();
        tests++;
        if (key_on !== 4'b0111 || loadF !== 4'b0000 || note_ready !== 1'b1) begin
            failed++;
            $display("FAIL off_none key=%b lf=%b rdy=%b exp 0111/0000/1", key_on, loadF, note_ready);
        end
    endtask

    task automatic test_retrigger();
        send(1'b1, 7'd64, 24'h000040, 16'h4000);
        tick();
        tests++;
        if (key_on !== 4'b0111 || steal_pulse !== 1'b0) begin
            failed++;
            $display("FAIL retrig_rel key=%b st=%b exp 0111/0", key_on, steal_pulse);
        end
        tick();
        tests++;
        if (key_on !== 4'b0011 || loadA !== 4'b0100 || A_bus !== 16'h4000) begin
            failed++;
            $display("FAIL retrig_load key=%b la=%b A=%h exp 0011/0100/4000", key_on, loadA, A_bus);
        end
        tick();
        tests++;
        if (key_on !== 4'b0111) begin
            failed++;
            $display("FAIL retrig_done key=%b exp=0111", key_on);
        end
    endtask

    task automatic test_panic();
        do_reset();
        send(1'b1, 7'd60, 24'h0A0000, 16'h8000);
        tick();
        panic = 1'b1;
        tick();
        tests++;
        if (key_on !== 4'b0000 || loadF !== 4'b0000 || note_ready !== 1'b0) begin
            failed++;
            $display("FAIL panic_edge key=%b lf=%b rdy=%b exp 0000/0000/0", key_on, loadF, note_ready);
        end
        note_on = 1'b1;
        note_num = 7'd62;
        note_valid = 1'b1;
        tick();
        tick();
        tests++;
        if (note_ready !== 1'b0 || key_on !== 4'b0000 || loadF !== 4'b0000) begin
            failed++;
            $display("FAIL panic_hold rdy=%b key=%b lf=%b exp 0/0000/0000", note_ready, key_on, loadF);
        end
        panic = 1'b0;
        note_valid = 1'b0;
        tick();
        tests++;
        if (note_ready !== 1'b1 || key_on !== 4'b0000) begin
            failed++;
            $display("FAIL panic_release rdy=%b key=%b exp 1/0000", note_ready, key_on);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        play(7'd60, 2);
        send(1'b1, 7'd62, 24'h0B0000, 16'h7000);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        tests++;
        if (key_on !== 4'b0000 || loadF !== 4'b0000 || F_bus !== 24'h0 || A_bus !== 16'h0) begin
            failed++;
            $display("FAIL rstmid key=%b lf=%b F=%h A=%h exp 0", key_on, loadF, F_bus, A_bus);
        end
        tick();
        tick();
        tests++;
        if (key_on !== 4'b0000 || loadF !== 4'b0000 || note_ready !== 1'b1) begin
            failed++;
            $display("FAIL rstmid_after key=%b lf=%b rdy=%b exp 0000/0000/1", key_on, loadF, note_ready);
        end
    endtask

    initial begin
        test_reset();
        test_free_voice();
        test_steal();
        test_note_off();
        test_off_unmatched();
        test_retrigger();
        test_panic();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
